seven_seg_scanner: RTL and testbench

SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

---
 rtl/seven_seg_scanner_pkg.sv | 22 ++
 rtl/seven_seg_scanner_bcd_digit_to_seg.sv | 29 ++
 rtl/seven_seg_scanner.sv | 129 ++++++++++++
 tb/tb_seven_seg_scanner.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_scanner_pkg.sv
// Shared constants for the multiplexed seven-segment scanner.
//   - Segment codes {a,b,c,d,e,f,g}, a at bit 6, active-high, for BCD 0..9
//   - Blank code used for invalid nibbles, blanked digits and display-off
//   - Default DIGITS / PRESCALE values for the top-level parameters
package seven_seg_scanner_pkg;

  localparam int DEFAULT_DIGITS   = 4;
  localparam int DEFAULT_PRESCALE = 50000;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/seven_seg_scanner_bcd_digit_to_seg.sv
// Combinational BCD nibble to seven-segment decoder.
//   bcd : 4-bit digit value
//   seg : segments {a,b,c,d,e,f,g}, active-high; all off for 10..15
module bcd_digit_to_seg
  import seven_seg_scanner_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // NOTE: the default arm covers every non-BCD code, so seg is assigned on
  // all paths and no latch is inferred.
  always_comb begin
    unique case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed BCD seven-segment display scanner with tear-free update.
//   clk, rst_n : clock, asynchronous active-low reset
//   value      : packed BCD word, nibble i = digit i (digit 0 least significant)
//   load       : capture value into the pending register (honoured when ready=1)
//   ready      : no word is pending; a new value may be loaded
//   lzb        : leading-zero blanking enable
//   blank      : display off (an all ones, seg off); scanning keeps running
//   seg        : registered segments {a..g}, active-high
//   an         : registered digit enables, active-low, one-hot-low
//   err        : registered, high while the displayed word holds a nibble > 9
module seven_seg_scanner
  import seven_seg_scanner_pkg::*;
#(
  parameter int DIGITS   = DEFAULT_DIGITS,
  parameter int PRESCALE = DEFAULT_PRESCALE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  output logic                  ready,
  input  logic                  lzb,
  input  logic                  blank,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  err
);

  localparam int PW = $clog2(PRESCALE);
  localparam int IW = $clog2(DIGITS);
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);

  logic [PW-1:0]       presc_q;
  logic [IW-1:0]       idx_q;
  logic [4*DIGITS-1:0] pend_q;
  logic                pend_valid_q;
  logic [4*DIGITS-1:0] disp_q;
  logic                run_q;

  logic                tick;
  logic                frame_end;
  logic [3:0]          sel_nib;
  logic [6:0]          dec_seg;
  logic [DIGITS-1:0]   zero_from;
  logic [DIGITS-1:0]   nib_err;
  logic [DIGITS-1:0]   an_next;
  logic                digit_off;

  assign tick      = (presc_q == PRESC_MAX);
  assign frame_end = tick && (idx_q == IDX_MAX);
  assign ready     = ~pend_valid_q;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values; the asynchronous reset branch comes first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else if (tick) begin
      presc_q <= '0;
      idx_q   <= (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  // A load is only possible with nothing pending, so it can never coincide
  // with a commit: a load in a frame_end cycle waits for the next frame_end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      disp_q       <= '0;
    end else if (load && ready) begin
      pend_q       <= value;
      pend_valid_q <= 1'b1;
    end else if (frame_end && pend_valid_q) begin
      disp_q       <= pend_q;
      pend_valid_q <= 1'b0;
    end
  end

  // Per-digit flags: digit g and everything above it are zero; digit g > 9.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    assign zero_from[g] = ~|disp_q[4*DIGITS-1 : 4*g];
    assign nib_err[g]   = (disp_q[4*g +: 4] > 4'd9);
  end

  always_comb begin
    sel_nib = disp_q[3:0];
    an_next = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        sel_nib    = disp_q[4*i +: 4];
        an_next[i] = 1'b0;
      end
    end
  end

  assign digit_off = lzb && (idx_q != '0) && zero_from[idx_q];

  bcd_digit_to_seg u_dec (
    .bcd (sel_nib),
    .seg (dec_seg)
  );

  // run_q holds the outputs at their reset values for the first edge after
  // reset release; scanning output starts on the second edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
      seg   <= SEG_BLANK;
      an    <= '1;
      err   <= 1'b0;
    end else begin
      run_q <= 1'b1;
      err   <= |nib_err;
      if (!run_q || blank) begin
        seg <= SEG_BLANK;
        an  <= '1;
      end else begin
        seg <= digit_off ? SEG_BLANK : dec_seg;
        an  <= an_next;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed self-checking bench for seven_seg_scanner (DIGITS=4, PRESCALE=4).
module tb_seven_seg_scanner;

  localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101,
                         S3 = 7'b1111001, S4 = 7'b0110011, S5 = 7'b1011011,
                         S6 = 7'b1011111, S7 = 7'b1110000, S8 = 7'b1111111,
                         SOFF = 7'b0000000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = '0;
  logic        load = 1'b0;
  logic        ready;
  logic        lzb = 1'b0;
  logic        blank = 1'b0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;
  int cnt;  // posedges since reset release; frame_end when cnt % 16 == 0

  seven_seg_scanner #(.DIGITS(4), .PRESCALE(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .value (value),
    .load  (load),
    .ready (ready),
    .lzb   (lzb),
    .blank (blank),
    .seg   (seg),
    .an    (an),
    .err   (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= 0;
    else        cnt <= cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for digit d to be enabled, then check its segments.
  task automatic show_digit(input string tag, input int d, input logic [6:0] exp);
    logic [3:0] pat;
    pat = ~(4'b0001 << d);
    for (int k = 0; k < 40 && an !== pat; k++) @(negedge clk);
    check({tag, "_an"}, 32'(an), 32'(pat));
    check({tag, "_seg"}, 32'(seg), 32'(exp));
  endtask

  task automatic wait_ready(input string tag);
    for (int k = 0; k < 40 && ready !== 1'b1; k++) @(negedge clk);
    check({tag, "_ready"}, 32'(ready), 32'd1);
  endtask

  task automatic do_load(input string tag, input logic [15:0] v);
    wait_ready(tag);
    value = v;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    check({tag, "_busy"}, 32'(ready), 32'd0);
  endtask

  // Load, then wait for the commit; returns at the first negedge after it.
  task automatic do_commit(input string tag, input logic [15:0] v);
    do_load(tag, v);
    @(negedge clk);
    wait_ready({tag, "_commit"});
  endtask

  initial begin
    // ---- reset values ----
    repeat (3) @(negedge clk);
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'(SOFF));
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;

    // ---- idle scan cadence ----
    @(negedge clk);
    check("first_edge_an", 32'(an), 32'hF);
    check("first_edge_seg", 32'(seg), 32'(SOFF));
    @(negedge clk);
    check("idle_d0_an", 32'(an), 32'b1110);
    check("idle_d0_seg", 32'(seg), 32'(S0));
    repeat (3) @(negedge clk);
    check("idle_d1_an", 32'(an), 32'b1101);
    check("idle_d1_seg", 32'(seg), 32'(S0));
    repeat (4) @(negedge clk);
    check("idle_d2_an", 32'(an), 32'b1011);
    repeat (4) @(negedge clk);
    check("idle_d3_an", 32'(an), 32'b0111);
    check("idle_d3_seg", 32'(seg), 32'(S0));
    repeat (4) @(negedge clk);
    check("idle_wrap_an", 32'(an), 32'b1110);
    check("idle_err", 32'(err), 32'd0);

    // ---- basic load / commit ----
    do_commit("l1234", 16'h1234);
    show_digit("l1234_d0", 0, S4);
    show_digit("l1234_d1", 1, S3);
    show_digit("l1234_d2", 2, S2);
    show_digit("l1234_d3", 3, S1);

    // ---- leading-zero blanking ----
    lzb = 1'b1;
    do_commit("l0050", 16'h0050);
    show_digit("l0050_d0", 0, S0);
    show_digit("l0050_d1", 1, S5);
    show_digit("l0050_d2", 2, SOFF);
    show_digit("l0050_d3", 3, SOFF);
    do_commit("l0000", 16'h0000);
    show_digit("l0000_d0", 0, S0);
    show_digit("l0000_d1", 1, SOFF);
    show_digit("l0000_d2", 2, SOFF);
    show_digit("l0000_d3", 3, SOFF);
    lzb = 1'b0;

    // ---- invalid nibble and err ----
    do_commit("l12a4", 16'h12A4);
    check("l12a4_err_commit", 32'(err), 32'd0);
    @(negedge clk);
    check("l12a4_err_next", 32'(err), 32'd1);
    show_digit("l12a4_d0", 0, S4);
    show_digit("l12a4_d1", 1, SOFF);
    do_commit("clr", 16'h1234);
    check("clr_err_commit", 32'(err), 32'd1);
    @(negedge clk);
    check("clr_err_next", 32'(err), 32'd0);

    // ---- load in frame_end cycle is deferred a full frame ----
    for (int k = 0; k < 40 && (cnt % 16) != 15; k++) @(negedge clk);
    check("fe_align", 32'(cnt % 16), 32'd15);
    check("fe_ready", 32'(ready), 32'd1);
    value = 16'h5678;
    load  = 1'b1;
    @(negedge clk);
    check("fe_busy", 32'(ready), 32'd0);
    value = 16'h1111;  // ignored: ready is low
    @(negedge clk);
    load  = 1'b0;
    repeat (14) @(negedge clk);
    check("fe_still_busy", 32'(ready), 32'd0);
    @(negedge clk);
    check("fe_commit_ready", 32'(ready), 32'd1);
    show_digit("fe_d0", 0, S8);
    show_digit("fe_d1", 1, S7);
    show_digit("fe_d2", 2, S6);
    show_digit("fe_d3", 3, S5);

    // ---- blank: outputs off, commit still proceeds ----
    blank = 1'b1;
    @(negedge clk);
    check("blank_an", 32'(an), 32'hF);
    check("blank_seg", 32'(seg), 32'(SOFF));
    do_commit("blank_l0042", 16'h0042);
    check("blank_hold_an", 32'(an), 32'hF);
    check("blank_hold_seg", 32'(seg), 32'(SOFF));
    blank = 1'b0;
    show_digit("unblank_d0", 0, S2);
    show_digit("unblank_d1", 1, S4);

    // ---- asynchronous reset with a pending word ----
    do_commit("pre_rst", 16'h12A4);
    @(negedge clk);
    check("pre_rst_err", 32'(err), 32'd1);
    do_load("pend", 16'h9876);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_an", 32'(an), 32'hF);
    check("arst_seg", 32'(seg), 32'(SOFF));
    check("arst_ready", 32'(ready), 32'd1);
    check("arst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    show_digit("post_d0", 0, S0);
    show_digit("post_d1", 1, S0);
    show_digit("post_d2", 2, S0);
    show_digit("post_d3", 3, S0);
    check("post_ready", 32'(ready), 32'd1);
    check("post_err", 32'(err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
